qix_hiscore_ctrl: RTL and testbench

Hiscore/NVRAM transfer engine sitting between the MiSTer ioctl channel and the Qix top level's hiscore port. It drives the core's hs_address, hs_write and write-data lines, and collects the core's read data. On a matching download it writes ioctl bytes into the core's CMOS RAM. On a matching upload it reads them back out. It also holds the CPUs paused while either transfer runs, so the game never observes a partially written table.

---
 rtl/qix_pkg.sv | 22 ++
 rtl/qix_hiscore_ctrl_if.sv | 38 +++
 rtl/qix_hiscore_ctrl.sv | 104 ++++++++++
 tb/tb_qix_hiscore_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/qix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qix_pkg
// Description : Shared types and default constants for the Qix hiscore engine.
// Revision    : 1.0 - initial release
// ============================================================================
package qix_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      RD_ADDR = 3'd2,
      RD_WAIT = 3'd3,
      RD_CAP  = 3'd4
   } hs_state_t;

   localparam logic [7:0]  QIX_HS_INDEX = 8'h04;
   localparam logic [15:0] QIX_HS_BASE  = 16'h8400;
   localparam int          QIX_HS_LEN   = 1024;

endpackage
`default_nettype wire

// File: rtl/qix_hiscore_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : qix_hiscore_ctrl_if
// Description : ioctl channel plus core hiscore port bundled as one bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface qix_hiscore_ctrl_if;

   logic        ioctl_download;
   logic        ioctl_upload;
   logic [7:0]  ioctl_index;
   logic [24:0] ioctl_addr;
   logic        ioctl_wr;
   logic [7:0]  ioctl_data;
   logic        ioctl_rd;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic [15:0] hs_address;
   logic [7:0]  hs_wdata;
   logic        hs_write;
   logic [7:0]  hs_rdata;

   // master: the transfer engine
   modport master (
      input  ioctl_download, ioctl_upload, ioctl_index, ioctl_addr,
             ioctl_wr, ioctl_data, ioctl_rd, hs_rdata,
      output ioctl_din, ioctl_wait, hs_address, hs_wdata, hs_write
   );

   // slave: ioctl source and core RAM side
   modport slave (
      output ioctl_download, ioctl_upload, ioctl_index, ioctl_addr,
             ioctl_wr, ioctl_data, ioctl_rd, hs_rdata,
      input  ioctl_din, ioctl_wait, hs_address, hs_wdata, hs_write
   );

endinterface
`default_nettype wire

// File: rtl/qix_hiscore_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : qix_hiscore_ctrl
// Description : Moves hiscore bytes between ioctl and core CMOS RAM, pausing CPUs.
// Revision    : 1.0 - initial release
// ============================================================================
module qix_hiscore_ctrl
   import qix_pkg::*;
#(
   parameter logic [7:0]  HS_INDEX = QIX_HS_INDEX,
   parameter logic [15:0] HS_BASE  = QIX_HS_BASE,
   parameter int          HS_LEN   = QIX_HS_LEN
) (
   input  wire                 clk_20m,
   input  wire                 reset,
   qix_hiscore_ctrl_if.master  bus,
   output logic                pause_cpu,
   output logic                hs_loaded
);

   hs_state_t   state;
   logic        rd_oob;
   logic        wrote_any;
   logic        dl_d;

   logic        sel;
   logic        dl_now;
   logic        xfer;
   logic        in_range;
   logic [15:0] addr_next;

   assign sel       = (bus.ioctl_index == HS_INDEX);
   assign dl_now    = bus.ioctl_download & sel;
   assign xfer      = (bus.ioctl_download | bus.ioctl_upload) & sel;
   assign in_range  = (bus.ioctl_addr < 25'(HS_LEN));
   assign addr_next = HS_BASE + bus.ioctl_addr[15:0];

   always_ff @(posedge clk_20m) begin
      if (reset) begin
         state          <= IDLE;
         rd_oob         <= 1'b0;
         wrote_any      <= 1'b0;
         dl_d           <= 1'b0;
         pause_cpu      <= 1'b0;
         hs_loaded      <= 1'b0;
         bus.hs_address <= '0;
         bus.hs_wdata   <= '0;
         bus.hs_write   <= 1'b0;
         bus.ioctl_din  <= '0;
         bus.ioctl_wait <= 1'b0;
      end else begin
         // Hold the pause until any in-flight access has drained back to IDLE
         pause_cpu <= xfer | (pause_cpu & (state != IDLE));

         dl_d <= dl_now;
         if (dl_d & ~dl_now) begin
            if (wrote_any) hs_loaded <= 1'b1;
            wrote_any <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (bus.ioctl_wr & bus.ioctl_download & sel) begin
                  state          <= WR;
                  bus.hs_address <= addr_next;
                  bus.hs_wdata   <= bus.ioctl_data;
                  bus.hs_write   <= in_range;
                  bus.ioctl_wait <= 1'b1;
                  if (in_range) wrote_any <= 1'b1;
               end else if (bus.ioctl_rd & bus.ioctl_upload & sel) begin
                  state          <= RD_ADDR;
                  bus.hs_address <= addr_next;
                  rd_oob         <= ~in_range;
                  bus.ioctl_wait <= 1'b1;
               end
            end
            WR: begin
               state          <= IDLE;
               bus.hs_write   <= 1'b0;
               bus.ioctl_wait <= 1'b0;
            end
            RD_ADDR: begin
               state <= RD_WAIT;
            end
            RD_WAIT: begin
               // RAM output now reflects the address presented in RD_ADDR
               state          <= RD_CAP;
               bus.ioctl_din  <= rd_oob ? 8'hFF : bus.hs_rdata;
               bus.ioctl_wait <= 1'b0;
            end
            RD_CAP: begin
               state <= IDLE;
            end
            default: begin
               state          <= IDLE;
               bus.hs_write   <= 1'b0;
               bus.ioctl_wait <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_qix_hiscore_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_qix_hiscore_ctrl
// Description : Scoreboard bench for qix_hiscore_ctrl with a behavioural core RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qix_hiscore_ctrl;
   import qix_pkg::*;

   localparam logic [15:0] BASE = 16'h8400;

   logic clk_20m = 1'b0;
   logic reset;
   logic pause_cpu;
   logic hs_loaded;

   qix_hiscore_ctrl_if bus ();

   qix_hiscore_ctrl dut (
      .clk_20m   (clk_20m),
      .reset     (reset),
      .bus       (bus),
      .pause_cpu (pause_cpu),
      .hs_loaded (hs_loaded)
   );

   always #5 clk_20m = ~clk_20m;

   // Core CMOS RAM: synchronous, one-cycle read latency
   logic [7:0] mem [0:65535];
   always @(posedge clk_20m) begin
      if (bus.hs_write) mem[bus.hs_address] <= bus.hs_wdata;
      bus.hs_rdata <= mem[bus.hs_address];
   end

   int checks   = 0;
   int failures = 0;

   logic [23:0] wq[$];   // {address, data} of expected hs_write pulses
   logic [7:0]  rq[$];   // expected ioctl_din per read

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk_20m) begin
      if (bus.hs_write === 1'b1) begin
         if (wq.size() == 0) begin
            chk("unexpected_write", {48'd0, bus.hs_address}, 64'hFFFF_FFFF);
         end else begin
            logic [23:0] e;
            e = wq.pop_front();
            chk("wr_addr", 64'(bus.hs_address), 64'(e[23:8]));
            chk("wr_data", 64'(bus.hs_wdata), 64'(e[7:0]));
         end
      end
   end

   task automatic step();
      @(posedge clk_20m);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, {28'd0, bus.hs_address, bus.hs_wdata, bus.hs_write, bus.ioctl_din,
                bus.ioctl_wait, pause_cpu, hs_loaded}, 64'd0);
      chk({tag, "_state"}, 64'(dut.state), 64'(IDLE));
   endtask

   task automatic do_write(input logic [24:0] addr, input logic [7:0] data,
                           input logic expect_wr, input logic also_rd);
      bus.ioctl_addr = addr;
      bus.ioctl_data = data;
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_rd   = also_rd;
      if (expect_wr) wq.push_back({BASE + addr[15:0], data});
      step();
      bus.ioctl_wr = 1'b0;
      bus.ioctl_rd = 1'b0;
      chk("wr_wait_hi", 64'(bus.ioctl_wait), 64'd1);
      chk("wr_pulse", 64'(bus.hs_write), 64'(expect_wr));
      step();
      chk("wr_wait_lo", 64'(bus.ioctl_wait), 64'd0);
      chk("wr_pulse_end", 64'(bus.hs_write), 64'd0);
   endtask

   task automatic do_read(input logic [24:0] addr, input logic [7:0] exp);
      logic [7:0] e;
      bus.ioctl_addr = addr;
      bus.ioctl_rd   = 1'b1;
      rq.push_back(exp);
      step();
      bus.ioctl_rd = 1'b0;
      chk("rd_wait_n1", 64'(bus.ioctl_wait), 64'd1);
      chk("rd_addr", 64'(bus.hs_address), 64'(BASE + addr[15:0]));
      step();
      chk("rd_wait_n2", 64'(bus.ioctl_wait), 64'd1);
      step();
      chk("rd_wait_n3", 64'(bus.ioctl_wait), 64'd0);
      e = rq.pop_front();
      chk("rd_din", 64'(bus.ioctl_din), 64'(e));
      step();
   endtask

   initial begin
      reset              = 1'b1;
      bus.ioctl_download = 1'b0;
      bus.ioctl_upload   = 1'b0;
      bus.ioctl_index    = 8'h04;
      bus.ioctl_addr     = '0;
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_data     = '0;
      bus.ioctl_rd       = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_all_zero("reset_idle");
      end

      // Download: two table bytes plus a marker byte for the upload test
      bus.ioctl_download = 1'b1;
      chk("pause_before", 64'(pause_cpu), 64'd0);
      step();
      chk("pause_rise", 64'(pause_cpu), 64'd1);
      do_write(25'd0, 8'h11, 1'b1, 1'b0);
      do_write(25'd1, 8'h22, 1'b1, 1'b0);
      do_write(25'd3, 8'hA5, 1'b1, 1'b0);
      bus.ioctl_download = 1'b0;
      chk("loaded_not_yet", 64'(hs_loaded), 64'd0);
      step();
      chk("loaded_set", 64'(hs_loaded), 64'd1);
      chk("pause_fall", 64'(pause_cpu), 64'd0);

      // Upload: in-range reads and an out-of-range read
      bus.ioctl_upload = 1'b1;
      step();
      do_read(25'd3, 8'hA5);
      do_read(25'd1, 8'h22);
      do_read(25'd1024, 8'hFF);
      bus.ioctl_upload = 1'b0;
      step();
      chk("loaded_hold_upload", 64'(hs_loaded), 64'd1);

      // Out-of-range write, then write/read collision
      bus.ioctl_download = 1'b1;
      bus.ioctl_upload   = 1'b1;
      step();
      do_write(25'd1024, 8'h5A, 1'b0, 1'b0);
      do_write(25'd2, 8'h77, 1'b1, 1'b1);
      repeat (3) begin
         step();
         chk("collide_din", 64'(bus.ioctl_din), 64'hFF);
         chk("collide_state", 64'(dut.state), 64'(IDLE));
      end
      bus.ioctl_download = 1'b0;
      bus.ioctl_upload   = 1'b0;
      repeat (2) step();

      // Wrong index: nothing may happen
      bus.ioctl_index    = 8'h00;
      bus.ioctl_download = 1'b1;
      bus.ioctl_upload   = 1'b1;
      bus.ioctl_wr       = 1'b1;
      bus.ioctl_rd       = 1'b1;
      repeat (2) step();
      bus.ioctl_wr = 1'b0;
      bus.ioctl_rd = 1'b0;
      repeat (3) begin
         step();
         chk("badidx_pause", 64'(pause_cpu), 64'd0);
         chk("badidx_wait", 64'(bus.ioctl_wait), 64'd0);
         chk("badidx_state", 64'(dut.state), 64'(IDLE));
      end
      bus.ioctl_download = 1'b0;
      bus.ioctl_upload   = 1'b0;
      bus.ioctl_index    = 8'h04;
      step();

      // Reset while a read sits in RD_WAIT
      bus.ioctl_upload = 1'b1;
      step();
      bus.ioctl_addr = 25'd3;
      bus.ioctl_rd   = 1'b1;
      step();
      bus.ioctl_rd = 1'b0;
      step();
      chk("in_rd_wait", 64'(dut.state), 64'(RD_WAIT));
      reset = 1'b1;
      step();
      chk_all_zero("mid_reset");
      reset            = 1'b0;
      bus.ioctl_upload = 1'b0;
      step();
      bus.ioctl_download = 1'b1;
      step();
      do_write(25'd5, 8'h33, 1'b1, 1'b0);
      bus.ioctl_download = 1'b0;
      step();
      chk("loaded_after_reset", 64'(hs_loaded), 64'd1);
      bus.ioctl_upload = 1'b1;
      step();
      do_read(25'd5, 8'h33);
      do_read(25'd2, 8'h77);
      bus.ioctl_upload = 1'b0;
      repeat (2) step();

      chk("writes_pending", 64'(wq.size()), 64'd0);
      chk("reads_pending", 64'(rq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
